// File: rtl/register_dump_unit.sv
// -----------------------------------------------------------------------------
// register_dump_unit
//
// When the host asks for a dump, this unit reads every register of the
// register file through the file's debug read port, starting at R0 and ending
// at R(N_REGISTERS-1). It sends each NB_DATA-bit value as NB_DATA/NB_BYTE
// bytes, most significant byte first, over a valid/ready byte stream that
// feeds the debug UART transmitter.
//
// Ports:
//   i_clock                   system clock; all state changes on the rising edge
//   i_reset                   asynchronous, active-high reset
//   i_start                   dump request, only looked at while idle
//   o_busy                    high from the cycle after the request is accepted
//                             until the completion cycle ends
//   o_done                    one-cycle completion pulse
//   o_read_reg_address_debug  debug read address to the register file
//   i_read_reg_data_debug     debug read data; the file updates it on the
//                             falling edge
//   o_tx_data                 byte to transmit
//   o_tx_valid                o_tx_data holds a valid byte
//   i_tx_ready                the TX sink accepts the byte this cycle
// -----------------------------------------------------------------------------
module register_dump_unit #(
  parameter int NB_DATA        = 32,
  parameter int N_REGISTERS    = 32,
  parameter int NB_REG_ADDRESS = 5,
  parameter int NB_BYTE        = 8
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NB_REG_ADDRESS-1:0] o_read_reg_address_debug,
  input  logic [NB_DATA-1:0]        i_read_reg_data_debug,
  output logic [NB_BYTE-1:0]        o_tx_data,
  output logic                      o_tx_valid,
  input  logic                      i_tx_ready
);

  localparam int N_BYTES  = NB_DATA / NB_BYTE;
  localparam int NB_COUNT = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  localparam logic [NB_COUNT-1:0]       LAST_BYTE = NB_COUNT'(N_BYTES - 1);
  localparam logic [NB_REG_ADDRESS-1:0] LAST_REG  = NB_REG_ADDRESS'(N_REGISTERS - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_ADDR = 2'd1,
    SEND     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_next;
  logic [NB_REG_ADDRESS-1:0]   reg_index;
  logic [NB_REG_ADDRESS-1:0]   reg_index_next;
  logic [NB_COUNT-1:0]         byte_count;
  logic [NB_COUNT-1:0]         byte_count_next;
  logic [NB_DATA-1:0]          word_buffer;
  logic [NB_DATA-1:0]          word_buffer_next;

  logic                        busy;
  logic                        busy_next;
  logic                        done;
  logic                        done_next;
  logic                        tx_valid;
  logic                        tx_valid_next;
  logic [NB_BYTE-1:0]          tx_data;
  logic [NB_BYTE-1:0]          tx_data_next;

  // The word buffer shifts left after every accepted byte, so the byte on the
  // wire is always the top slice. This gives MSB-first order without needing
  // a byte-select multiplexer.
  function automatic logic [NB_BYTE-1:0] top_byte(input logic [NB_DATA-1:0] word);
    return word[NB_DATA-1 -: NB_BYTE];
  endfunction

  // State register, datapath registers and registered outputs
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      reg_index   <= '0;
      byte_count  <= '0;
      word_buffer <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
    end else begin
      state       <= state_next;
      reg_index   <= reg_index_next;
      byte_count  <= byte_count_next;
      word_buffer <= word_buffer_next;
      busy        <= busy_next;
      done        <= done_next;
      tx_valid    <= tx_valid_next;
      tx_data     <= tx_data_next;
    end
  end

  // Next-state logic and next values of the registered outputs
  always_comb begin
    state_next       = state;
    reg_index_next   = reg_index;
    byte_count_next  = byte_count;
    word_buffer_next = word_buffer;

    case (state)
      IDLE: begin
        if (i_start) begin
          state_next     = SET_ADDR;
          reg_index_next = '0;
        end else begin
          state_next = IDLE;
        end
      end

      // The address has been stable since the start of this cycle. The file
      // updates its read data on the falling edge, so the data is valid when
      // the closing rising edge captures it.
      SET_ADDR: begin
        state_next       = SEND;
        word_buffer_next = i_read_reg_data_debug;
        byte_count_next  = '0;
      end

      SEND: begin
        if (i_tx_ready) begin
          if (byte_count != LAST_BYTE) begin
            byte_count_next  = byte_count + NB_COUNT'(1);
            word_buffer_next = word_buffer << NB_BYTE;
          end else if (reg_index != LAST_REG) begin
            reg_index_next = reg_index + NB_REG_ADDRESS'(1);
            state_next     = SET_ADDR;
          end else begin
            state_next = DONE;
          end
        end else begin
          state_next = SEND;
        end
      end

      DONE: begin
        state_next     = IDLE;
        reg_index_next = '0;
      end

      default: begin
        state_next     = IDLE;
        reg_index_next = '0;
      end
    endcase

    // The outputs are worked out from the next state so that each output
    // register holds the value for the state being entered.
    busy_next     = (state_next != IDLE);
    done_next     = (state_next == DONE);
    tx_valid_next = (state_next == SEND);
    if (state_next == SEND) begin
      tx_data_next = top_byte(word_buffer_next);
    end else begin
      tx_data_next = '0;
    end
  end

  assign o_busy                   = busy;
  assign o_done                   = done;
  assign o_tx_valid               = tx_valid;
  assign o_tx_data                = tx_data;
  assign o_read_reg_address_debug = reg_index;

endmodule

// File: tb/tb_register_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_register_dump_unit
//
// Scoreboard bench for register_dump_unit. Each dump request pushes the full
// expected byte stream into a queue. Each entry holds a byte and the register
// it comes from. A monitor on the falling edge compares every presented byte
// and the debug address against the head of the queue. It pops the head only
// when the byte is actually accepted. A behavioural register file answers the
// debug port on the falling edge.
// -----------------------------------------------------------------------------
module tb_register_dump_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  addr;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        ready;

  register_dump_unit dut (
    .i_clock                  (clk),
    .i_reset                  (rst),
    .i_start                  (start),
    .o_busy                   (busy),
    .o_done                   (done),
    .o_read_reg_address_debug (addr),
    .i_read_reg_data_debug    (rd_data),
    .o_tx_data                (tx_data),
    .o_tx_valid               (tx_valid),
    .i_tx_ready               (ready)
  );

  typedef struct {
    logic [7:0] b;
    int         r;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] reg_model [32];

  int vectors      = 0;
  int errors       = 0;
  int pops         = 0;
  int done_count   = 0;
  int stall_cycles = 0;
  int mode         = 0;
  int stall_left   = 0;
  bit stall_armed  = 1'b0;

  always #5 clk = ~clk;

  // Behavioural register file: the read data follows the address on the falling edge
  always @(negedge clk) rd_data <= reg_model[addr];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Expected stream for one dump of the current register contents
  task automatic push_dump();
    logic [31:0] w;
    for (int r = 0; r < 32; r++) begin
      w = reg_model[r];
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back('{b: 8'(w >> (24 - 8 * b)), r: r});
      end
    end
  endtask

  // Ready driver: constant, alternating or random, plus a one-time 3-cycle stall on 0xBE of R1
  always @(posedge clk) begin
    #1;
    case (mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      2:       ready = 1'($urandom_range(0, 1));
      default: ready = 1'b1;
    endcase
    if (stall_left > 0) begin
      ready = 1'b0;
      stall_left--;
    end else if (stall_armed && tx_valid && tx_data == 8'hBE && addr == 5'd1) begin
      ready       = 1'b0;
      stall_armed = 1'b0;
      stall_left  = 2;
    end
  end

  // Monitor: compare the presented byte and address with the scoreboard head
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_count++;
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_byte", 32'd1, 32'd0);
        end else begin
          check("tx_data", 32'(tx_data), 32'(exp_q[0].b));
          check("send_address", 32'(addr), 32'(exp_q[0].r));
          if (!ready && tx_data == 8'hBE && addr == 5'd1) stall_cycles++;
          if (ready) begin
            void'(exp_q.pop_front());
            pops++;
          end
        end
      end else begin
        check("idle_tx_data", 32'(tx_data), 32'd0);
        if (busy && !done && exp_q.size() > 0)
          check("setaddr_address", 32'(addr), 32'(exp_q[0].r));
      end
    end
  end

  task automatic run_dump(input int lat_min, input int lat_max, input bit extra);
    int n;
    int d0;
    pops = 0;
    d0   = done_count;
    push_dump();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (n < 6000) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      n++;
      #1 start = extra && (n == 10 || n == 50);
    end
    start = 1'b0;
    vectors++;
    if (n < lat_min || n > lat_max) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d..%0d", n, lat_min, lat_max);
    end
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("byte_count", 32'(pops), 32'd128);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_count - d0), 32'd1);
  endtask

  initial begin
    int n;
    int d0;
    clk   = 1'b0;
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 32; k++) reg_model[k] = 32'(k);
    reg_model[1]  = 32'hDEADBEEF;
    reg_model[31] = 32'h0000001F;

    // Asynchronous reset before any clock edge
    #3 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("quiet_outputs", 32'({busy, done, tx_valid, tx_data, addr}), 32'd0);
    end

    // Full dump with ready held high
    run_dump(160, 160, 1'b0);

    // Backpressure on byte 0xBE of R1
    stall_cycles = 0;
    stall_armed  = 1'b1;
    run_dump(163, 163, 1'b0);
    check("stall_cycles", 32'(stall_cycles), 32'd3);

    // Extra start pulses while busy, then a second identical dump
    run_dump(160, 160, 1'b1);
    run_dump(160, 160, 1'b0);

    // Alternating ready
    mode = 1;
    run_dump(160, 288, 1'b0);

    // Random data with random ready
    mode = 2;
    for (int k = 0; k < 32; k++) reg_model[k] = $urandom;
    run_dump(160, 5000, 1'b0);

    // Reset while byte 2 of R7 is on the wire
    mode = 0;
    repeat (2) @(posedge clk);
    pops = 0;
    d0   = done_count;
    push_dump();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (n < 500 && !(pops == 30 && tx_valid)) begin
      @(posedge clk); #2;
      n++;
    end
    check("reach_r7_byte2", 32'(addr), 32'd7);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_addr", 32'(addr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_done", 32'(done_count - d0), 32'd0);
    run_dump(160, 160, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
